// File: rtl/mem_port_arbiter.sv
// =============================================================================
// mem_port_arbiter : shares one memory port between the core and a host port
// Revision 1.0 : initial release
// =============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int ADDR_W         = 11,
   parameter int DATA_W         = 16,
   parameter int STARVE_LIMIT   = 8,
   parameter int HOST_MAX_BURST = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [ADDR_W-1:0] core_addr_i,
   input  logic [DATA_W-1:0] core_wdata_i,
   output logic              core_gnt_o,
   output logic              core_stall_o,
   output logic              core_rvalid_o,
   output logic [DATA_W-1:0] core_rdata_o,
   input  logic              host_req_i,
   input  logic              host_we_i,
   input  logic [ADDR_W-1:0] host_addr_i,
   input  logic [DATA_W-1:0] host_wdata_i,
   output logic              host_gnt_o,
   output logic              host_rvalid_o,
   output logic [DATA_W-1:0] host_rdata_o,
   output logic              mem_en_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   localparam int WAIT_W  = $clog2(STARVE_LIMIT + 1);
   localparam int BURST_W = $clog2(HOST_MAX_BURST + 1);
   localparam logic [WAIT_W-1:0]  c_WAIT_MAX  = WAIT_W'(STARVE_LIMIT);
   localparam logic [BURST_W-1:0] c_BURST_MAX = BURST_W'(HOST_MAX_BURST);

   logic [WAIT_W-1:0]  host_wait_q,  host_wait_d;
   logic [BURST_W-1:0] host_burst_q, host_burst_d;
   logic [1:0]         rd_owner_q,   rd_owner_d;

   logic w_host_pri;
   logic w_host_blk;

   assign w_host_pri = host_req_i & (host_wait_q == c_WAIT_MAX);
   assign w_host_blk = core_req_i & (host_burst_q == c_BURST_MAX);

   // Reset gates every grant so no access can reach the memory while rst_i is low.
   assign host_gnt_o   = rst_i & host_req_i & ~w_host_blk & (~core_req_i | w_host_pri);
   assign core_gnt_o   = rst_i & core_req_i & ~host_gnt_o;
   assign core_stall_o = rst_i & core_req_i & ~core_gnt_o;

   assign mem_en_o = core_gnt_o | host_gnt_o;

   always_comb begin
      mem_write_o = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (core_gnt_o) begin
         mem_write_o = core_we_i;
         mem_addr_o  = core_addr_i;
         mem_wdata_o = core_wdata_i;
      end else if (host_gnt_o) begin
         mem_write_o = host_we_i;
         mem_addr_o  = host_addr_i;
         mem_wdata_o = host_wdata_i;
      end
   end

   always_comb begin
      host_wait_d = '0;
      if (host_req_i && !host_gnt_o) begin
         host_wait_d = (host_wait_q == c_WAIT_MAX) ? host_wait_q : host_wait_q + WAIT_W'(1);
      end
      // With core_req high exactly one side is granted, so the burst count never holds.
      host_burst_d = '0;
      if (host_gnt_o && core_req_i) begin
         host_burst_d = (host_burst_q == c_BURST_MAX) ? host_burst_q : host_burst_q + BURST_W'(1);
      end
      rd_owner_d = {host_gnt_o & ~host_we_i, core_gnt_o & ~core_we_i};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         host_wait_q  <= '0;
         host_burst_q <= '0;
         rd_owner_q   <= '0;
      end else begin
         host_wait_q  <= host_wait_d;
         host_burst_q <= host_burst_d;
         rd_owner_q   <= rd_owner_d;
      end
   end

   assign core_rvalid_o = rd_owner_q[0];
   assign host_rvalid_o = rd_owner_q[1];
   assign core_rdata_o  = mem_rdata_i;
   assign host_rdata_o  = mem_rdata_i;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// =============================================================================
// tb_mem_port_arbiter : directed and randomized checks of mem_port_arbiter
// Revision 1.0 : initial release
// =============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   localparam int ADDR_W         = 11;
   localparam int DATA_W         = 16;
   localparam int STARVE_LIMIT   = 8;
   localparam int HOST_MAX_BURST = 4;

   logic              clk = 1'b0;
   logic              rst_i = 1'b0;
   logic              core_req_i = 1'b0, core_we_i = 1'b0;
   logic [ADDR_W-1:0] core_addr_i = '0;
   logic [DATA_W-1:0] core_wdata_i = '0;
   logic              host_req_i = 1'b0, host_we_i = 1'b0;
   logic [ADDR_W-1:0] host_addr_i = '0;
   logic [DATA_W-1:0] host_wdata_i = '0;
   logic              core_gnt_o, core_stall_o, core_rvalid_o;
   logic [DATA_W-1:0] core_rdata_o;
   logic              host_gnt_o, host_rvalid_o;
   logic [DATA_W-1:0] host_rdata_o;
   logic              mem_en_o, mem_write_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i = '0;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .STARVE_LIMIT(STARVE_LIMIT), .HOST_MAX_BURST(HOST_MAX_BURST)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .core_req_i(core_req_i), .core_we_i(core_we_i),
      .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
      .core_gnt_o(core_gnt_o), .core_stall_o(core_stall_o),
      .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
      .host_req_i(host_req_i), .host_we_i(host_we_i),
      .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
      .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
      .host_rdata_o(host_rdata_o),
      .mem_en_o(mem_en_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i)
   );

   function automatic logic [DATA_W-1:0] dflt(input logic [ADDR_W-1:0] a);
      return DATA_W'(a) * 16'h9E37 ^ 16'h5A5A;
   endfunction

   // Memory macro driven by the DUT's port, one-cycle read latency.
   bit [DATA_W-1:0] mem   [2**ADDR_W];
   bit              mem_v [2**ADDR_W];
   always @(posedge clk) begin
      if (mem_en_o && mem_write_o) begin
         mem[mem_addr_o]   <= mem_wdata_o;
         mem_v[mem_addr_o] <= 1'b1;
      end
      if (mem_en_o && !mem_write_o)
         mem_rdata_i <= mem_v[mem_addr_o] ? mem[mem_addr_o] : dflt(mem_addr_o);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: who wins the port follows the arbitration rules directly,
   // and read data comes from a shadow memory written by the model's own decisions.
   int              m_wait = 0, m_burst = 0;
   bit              m_crv = 0, m_hrv = 0;
   logic [DATA_W-1:0] m_cdat = '0, m_hdat = '0;
   bit [DATA_W-1:0] sh   [2**ADDR_W];
   bit              sh_v [2**ADDR_W];

   always @(negedge clk) begin
      int                who;
      logic              e_we;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wd;
      who = 0;
      if (rst_i) begin
         if (host_req_i && !core_req_i) who = 2;
         else if (host_req_i && core_req_i && m_wait >= STARVE_LIMIT
                  && m_burst < HOST_MAX_BURST) who = 2;
         else if (core_req_i) who = 1;
      end
      e_we = 1'b0; e_addr = '0; e_wd = '0;
      if (who == 1) begin e_we = core_we_i; e_addr = core_addr_i; e_wd = core_wdata_i; end
      if (who == 2) begin e_we = host_we_i; e_addr = host_addr_i; e_wd = host_wdata_i; end

      if (chk_en) begin
         check("core_gnt", {31'b0, core_gnt_o}, {31'b0, who == 1});
         check("host_gnt", {31'b0, host_gnt_o}, {31'b0, who == 2});
         check("core_stall", {31'b0, core_stall_o}, {31'b0, rst_i && core_req_i && who != 1});
         check("mem_en", {31'b0, mem_en_o}, {31'b0, who != 0});
         check("mem_write", {31'b0, mem_write_o}, {31'b0, e_we});
         check("mem_addr", 32'(mem_addr_o), 32'(e_addr));
         check("mem_wdata", 32'(mem_wdata_o), 32'(e_wd));
         check("core_rvalid", {31'b0, core_rvalid_o}, {31'b0, m_crv});
         check("host_rvalid", {31'b0, host_rvalid_o}, {31'b0, m_hrv});
         if (m_crv) check("core_rdata", 32'(core_rdata_o), 32'(m_cdat));
         if (m_hrv) check("host_rdata", 32'(host_rdata_o), 32'(m_hdat));
      end

      if (!rst_i) begin
         m_wait = 0; m_burst = 0; m_crv = 0; m_hrv = 0;
      end else begin
         m_wait  = (host_req_i && who != 2) ? ((m_wait < STARVE_LIMIT) ? m_wait + 1 : m_wait) : 0;
         m_burst = (who == 2 && core_req_i) ? ((m_burst < HOST_MAX_BURST) ? m_burst + 1 : m_burst) : 0;
         m_crv = (who == 1) && !e_we;
         m_hrv = (who == 2) && !e_we;
         if (who != 0 && !e_we) begin
            if (who == 1) m_cdat = sh_v[e_addr] ? sh[e_addr] : dflt(e_addr);
            else          m_hdat = sh_v[e_addr] ? sh[e_addr] : dflt(e_addr);
         end
         if (who != 0 && e_we) begin
            sh[e_addr] = e_wd; sh_v[e_addr] = 1'b1;
         end
      end
   end

   task automatic cyc_start(); @(posedge clk); #1; endtask
   task automatic cyc_mid();   @(negedge clk); #1; endtask

   task automatic set_core(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
      core_req_i = r; core_we_i = w; core_addr_i = a; core_wdata_i = d;
   endtask

   task automatic set_host(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
      host_req_i = r; host_we_i = w; host_addr_i = a; host_wdata_i = d;
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom);
      return ADDR_W'($urandom_range(0, 15));
   endfunction

   initial begin
      bit c_g, h_g;
      int pc, ph;
      c_g = 0; h_g = 0;
      repeat (2) @(posedge clk);
      cyc_start(); rst_i = 1'b1; chk_en = 1'b1;

      // Preload 0x1234 at 0x005 via the host port.
      set_host(1, 1, 11'h005, 16'h1234);
      cyc_mid(); check("preload_gnt", {31'b0, host_gnt_o}, 32'd1);

      // Lone core read of 0x005.
      cyc_start(); set_host(0, 0, 0, 0); set_core(1, 0, 11'h005, 0);
      cyc_mid();
      check("t1_gnt", {31'b0, core_gnt_o}, 32'd1);
      check("t1_en", {31'b0, mem_en_o}, 32'd1);
      check("t1_we", {31'b0, mem_write_o}, 32'd0);
      check("t1_addr", 32'(mem_addr_o), 32'h005);
      cyc_start(); set_core(0, 0, 0, 0);
      cyc_mid();
      check("t1_rvalid", {31'b0, core_rvalid_o}, 32'd1);
      check("t1_rdata", 32'(core_rdata_o), 32'h1234);
      check("t1_hrvalid", {31'b0, host_rvalid_o}, 32'd0);

      // Both request continuously from idle: core 8 times, then starved host once.
      cyc_start(); set_core(1, 0, 11'h020, 0); set_host(1, 1, 11'h100, 16'hCAFE);
      for (int i = 1; i <= 10; i++) begin
         cyc_mid();
         if (i <= 8) begin
            check("t2_core_gnt", {31'b0, core_gnt_o}, 32'd1);
            check("t2_host_wait", {31'b0, host_gnt_o}, 32'd0);
         end else if (i == 9) begin
            check("t2_host_gnt", {31'b0, host_gnt_o}, 32'd1);
            check("t2_stall", {31'b0, core_stall_o}, 32'd1);
         end else begin
            check("t2_core_again", {31'b0, core_gnt_o}, 32'd1);
         end
         cyc_start();
      end
      set_core(0, 0, 0, 0); set_host(0, 0, 0, 0);
      cyc_mid();

      // Host write to 0x7FF then core read-back.
      cyc_start(); set_host(1, 1, 11'h7FF, 16'hBEEF);
      cyc_mid();
      check("t4_we", {31'b0, mem_write_o}, 32'd1);
      check("t4_addr", 32'(mem_addr_o), 32'h7FF);
      check("t4_wdata", 32'(mem_wdata_o), 32'hBEEF);
      cyc_start(); set_host(0, 0, 0, 0); set_core(1, 0, 11'h7FF, 0);
      cyc_mid(); check("t4_core_gnt", {31'b0, core_gnt_o}, 32'd1);
      cyc_start(); set_core(0, 0, 0, 0);
      cyc_mid();
      check("t4_rvalid", {31'b0, core_rvalid_o}, 32'd1);
      check("t4_rdata", 32'(core_rdata_o), 32'hBEEF);
      check("t4_hrvalid", {31'b0, host_rvalid_o}, 32'd0);

      // Reset right after a core read grant, with both sides requesting.
      cyc_start(); set_core(1, 0, 11'h7FF, 0);
      cyc_mid(); check("t5_gnt", {31'b0, core_gnt_o}, 32'd1);
      cyc_start(); rst_i = 1'b0; set_host(1, 0, 11'h003, 0);
      cyc_mid();
      check("t5_rst_cgnt", {31'b0, core_gnt_o}, 32'd0);
      check("t5_rst_hgnt", {31'b0, host_gnt_o}, 32'd0);
      check("t5_rst_en", {31'b0, mem_en_o}, 32'd0);
      check("t5_rst_stall", {31'b0, core_stall_o}, 32'd0);
      cyc_start();
      cyc_mid();
      check("t5_rvalid_drop", {31'b0, core_rvalid_o}, 32'd0);
      check("t5_rst_en2", {31'b0, mem_en_o}, 32'd0);
      cyc_start(); rst_i = 1'b1;
      cyc_mid();
      check("t5_post_core", {31'b0, core_gnt_o}, 32'd1);
      check("t5_post_host", {31'b0, host_gnt_o}, 32'd0);
      cyc_start(); set_core(0, 0, 0, 0); set_host(0, 0, 0, 0);
      cyc_mid();

      // Randomized traffic with varying request densities and occasional resets.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         cyc_start();
         case ((cyc / 500) % 4)
            0: begin pc = 95; ph = 95; end
            1: begin pc = 50; ph = 50; end
            2: begin pc = 99; ph = 30; end
            default: begin pc = 20; ph = 90; end
         endcase
         if (!core_req_i || c_g)
            set_core($urandom_range(0, 99) < pc, 1'($urandom), rand_addr(), DATA_W'($urandom));
         else if ($urandom_range(0, 19) == 0)
            core_req_i = 1'b0;
         if (!host_req_i || h_g)
            set_host($urandom_range(0, 99) < ph, 1'($urandom), rand_addr(), DATA_W'($urandom));
         else if ($urandom_range(0, 19) == 0)
            host_req_i = 1'b0;
         rst_i = ($urandom_range(0, 199) != 0);
         cyc_mid();
         c_g = core_gnt_o; h_g = host_gnt_o;
      end

      cyc_start(); set_core(0, 0, 0, 0); set_host(0, 0, 0, 0); rst_i = 1'b1;
      cyc_mid();
      cyc_start();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
